// File: rtl/seq_mul_gen.sv
// seq_mul_gen: sequential shift-and-add multiplier, one multiplier bit per cycle.
// Operands are converted to magnitudes on start and the sign is applied in FIX,
// so the accumulator never overflows, including -2^(N-1) * -2^(N-1).
// The optional early-exit feature is enabled by defining SEQ_MUL_EARLY_EXIT_EN.
// Without it, RUN always lasts N cycles. Product values are the same in both builds.
// Handshake: start is accepted only in IDLE or DONE. busy is high while the operation
// is in flight (RUN, FIX). done pulses for exactly one cycle in DONE, when product and
// run_cycles become valid. product holds until the next FIX.
module seq_mul_gen #(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    output logic [2*N-1:0]   product,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    run_cycles,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state;
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;
    logic [2*N-1:0] acc;
    logic           neg;
    logic [CW-1:0]  cnt;

    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;
    logic [N-1:0]   mplier_next;
    logic           last_step;

    assign dbg_state = state;

    // Operand magnitudes and the RUN exit condition for the current cycle
    always_comb begin
        a_mag       = (signed_op && A[N-1]) ? (~A + 1'b1) : A;
        b_mag       = (signed_op && B[N-1]) ? (~B + 1'b1) : B;
        mplier_next = mplier >> 1;
`ifdef SEQ_MUL_EARLY_EXIT_EN
        last_step   = (mplier_next == '0);
`else
        last_step   = (cnt == CW'(N - 1));
`endif
    end

    // Control FSM with datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            neg        <= 1'b0;
            cnt        <= '0;
            product    <= '0;
            run_cycles <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand  <= {{N{1'b0}}, a_mag};
                        mplier <= b_mag;
                        neg    <= signed_op & (A[N-1] ^ B[N-1]);
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier_next;
                    cnt    <= cnt + 1'b1;
                    if (last_step) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    product    <= neg ? (~acc + 1'b1) : acc;
                    run_cycles <= cnt;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    state      <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul_gen.sv
// tb_seq_mul_gen: directed vectors with hand-computed products; expected results
// are queued at issue time and checked by an independent monitor on done.
module tb_seq_mul_gen;

  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);
  localparam int W  = 2 * N + CW;

  logic            clk;
  logic            rst;
  logic            start;
  logic            signed_op;
  logic [N-1:0]    a_in;
  logic [N-1:0]    b_in;
  logic [2*N-1:0]  product;
  logic            busy;
  logic            done;
  logic [CW-1:0]   run_cycles;
  logic [1:0]      dbg_state;

  logic [W-1:0] exp_q[$];
  int           edge_q[$];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int done_count = 0;

  seq_mul_gen #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_op  (signed_op),
    .A          (a_in),
    .B          (b_in),
    .product    (product),
    .busy       (busy),
    .done       (done),
    .run_cycles (run_cycles),
    .dbg_state  (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // expected number of RUN cycles for a given multiplier
  function automatic int exp_r(input logic s, input logic [N-1:0] b);
    logic [N-1:0] mag;
    int r;
    mag = (s && b[N-1]) ? (~b + 1'b1) : b;
`ifdef SEQ_MUL_EARLY_EXIT_EN
    r = 1;
    for (int i = 0; i < N; i++) if (mag[i]) r = i + 1;
`else
    r = N;
`endif
    return r;
  endfunction

  // monitor: pop and compare on every done pulse
  always @(negedge clk) begin
    if (rst && done) begin
      logic [W-1:0] e;
      int se;
      done_count++;
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        e  = exp_q.pop_front();
        se = edge_q.pop_front();
        check("product", 64'(product), 64'(e[W-1:CW]));
        check("run_cycles", 64'(run_cycles), 64'(e[CW-1:0]));
        check("done_latency", 64'(cyc), 64'(se + int'(e[CW-1:0]) + 1));
      end
    end
  end

  // driver: present one operation at a negedge; expectation queued once accepted
  task automatic issue(input logic s, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [2*N-1:0] prod);
    start     = 1'b1;
    signed_op = s;
    a_in      = a;
    b_in      = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_q.push_back({prod, CW'(exp_r(s, b))});
    edge_q.push_back(cyc);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
      edge_q.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int dc;
    int t;
    rst       = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    a_in      = '0;
    b_in      = '0;
    repeat (3) @(negedge clk);
    check("rst_product", 64'(product), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_run_cycles", 64'(run_cycles), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // directed vectors
    issue(1'b0, 8'd200, 8'd150, 16'h7530); drain();
    issue(1'b1, 8'hFD,  8'h07,  16'hFFEB); drain();
    issue(1'b1, 8'h80,  8'h80,  16'h4000); drain();
    issue(1'b0, 8'hFF,  8'h01,  16'h00FF); drain();
    issue(1'b0, 8'hFF,  8'h00,  16'h0000); drain();
    issue(1'b0, 8'hFF,  8'hFF,  16'hFE01); drain();
    issue(1'b1, 8'hFF,  8'hFF,  16'h0001); drain();
    issue(1'b1, 8'h80,  8'h7F,  16'hC080); drain();
    issue(1'b1, 8'h05,  8'hFC,  16'hFFEC); drain();
    issue(1'b0, 8'h80,  8'h80,  16'h4000); drain();

    // start while busy is ignored
    dc = done_count;
    issue(1'b0, 8'd200, 8'd150, 16'h7530);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; signed_op = 1'b1; a_in = 8'd3; b_in = 8'd5;
    @(negedge clk);
    start = 1'b0;
    drain();
    check("busy_start_one_done", 64'(done_count - dc), 64'd1);

    // back-to-back: start held in DONE
    issue(1'b0, 8'd200, 8'd150, 16'h7530);
    t = 0;
    while (!done && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("b2b_done_seen", 64'(done), 64'd1);
    start = 1'b1; signed_op = 1'b0; a_in = 8'd3; b_in = 8'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_q.push_back({16'd15, CW'(exp_r(1'b0, 8'd5))});
    edge_q.push_back(cyc);
    check("b2b_busy", 64'(busy), 64'd1);
    check("b2b_state_run", 64'(dbg_state), 64'd1);
    drain();

    // reset mid-operation
    issue(1'b0, 8'd200, 8'd150, 16'h7530);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_product", 64'(product), 64'd0);
    exp_q.delete();
    edge_q.delete();
    @(negedge clk);
    rst = 1'b1;
    dc = done_count;
    repeat (15) @(negedge clk);
    check("midrst_no_done", 64'(done_count - dc), 64'd0);
    check("midrst_product_held", 64'(product), 64'd0);
    issue(1'b1, 8'hFD, 8'h07, 16'hFFEB); drain();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
